// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Word width, state encoding and default encodings for NOP / HALT / reset PC.
package fetch_pkg;

    localparam int WORD_W = 16;
    localparam int OP_W   = 5;

    localparam logic [WORD_W-1:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [WORD_W-1:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [OP_W-1:0]   HALT_OP_DEF   = 5'b00000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MISS   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    function automatic logic [OP_W-1:0] opcode(input logic [WORD_W-1:0] word);
        return word[WORD_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid buffer holding {pc_plus2, instr} while decode stalls.
// Registered: loaded word is visible the cycle after i_load; i_clear wins over i_load.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [WORD_W-1:0] i_pc_plus2,
    input  logic [WORD_W-1:0] i_instr,
    output logic              o_vld,
    output logic [WORD_W-1:0] o_pc_plus2,
    output logic [WORD_W-1:0] o_instr
);

    logic              r_vld;
    logic [WORD_W-1:0] r_pc_plus2;
    logic [WORD_W-1:0] r_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld      <= 1'b0;
            r_pc_plus2 <= '0;
            r_instr    <= '0;
        end else begin
            if (i_clear) begin
                r_vld <= 1'b0;
            end else if (i_load) begin
                r_vld      <= 1'b1;
                r_pc_plus2 <= i_pc_plus2;
                r_instr    <= i_instr;
            end
        end
    end

    assign o_vld      = r_vld;
    assign o_pc_plus2 = r_pc_plus2;
    assign o_instr    = r_instr;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives the I-cache handshake and builds every IF/ID input
// combinationally (0 cycles); decode stall is absorbed by a one-word hold buffer. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [OP_W-1:0]   HALT_OP   = HALT_OP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              ic_req,
    output logic [WORD_W-1:0] ic_addr,
    input  logic [WORD_W-1:0] ic_rdata,
    input  logic              ic_done,
    input  logic              ic_stall,
    output logic              ifid_we,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_instr,
    output logic              ifid_flush,
    output logic              ifid_istall
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_miss_cyc
`endif
);

    fetch_state_t      r_state, w_state_nxt;
    logic [WORD_W-1:0] r_pc, w_pc_nxt;
    logic [WORD_W-1:0] r_tgt, w_tgt_nxt;
    logic [WORD_W-1:0] w_pc_plus2;
    logic              w_accept;
    logic              w_buf_load, w_buf_clear;
    logic              w_buf_vld;
    logic [WORD_W-1:0] w_buf_pc_plus2, w_buf_instr;
    logic              w_in_miss;

    assign w_pc_plus2 = r_pc + WORD_W'(2);
    assign w_in_miss  = (r_state == ST_MISS) || (r_state == ST_DRAIN);
    assign ic_addr    = r_pc;

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_buf_load),
        .i_clear    (w_buf_clear),
        .i_pc_plus2 (w_pc_plus2),
        .i_instr    (ic_rdata),
        .o_vld      (w_buf_vld),
        .o_pc_plus2 (w_buf_pc_plus2),
        .o_instr    (w_buf_instr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_tgt   <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_tgt   <= w_tgt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt;
        w_accept    = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        ic_req      = 1'b0;
        ifid_we     = 1'b0;
        ifid_pc     = '0;
        ifid_instr  = NOP_INSTR;
        ifid_flush  = 1'b0;
        ifid_istall = 1'b0;

        if (redirect_valid) begin
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            w_buf_clear = 1'b1;
            // An access still in flight must complete before the new target may be fetched.
            ic_req      = w_in_miss;
            if (w_in_miss && !ic_done) begin
                w_tgt_nxt   = redirect_pc;
                w_state_nxt = ST_DRAIN;
            end else begin
                w_pc_nxt    = redirect_pc;
                w_state_nxt = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_buf_vld) begin
                        if (!stall_in) begin
                            ifid_we     = 1'b1;
                            ifid_pc     = w_buf_pc_plus2;
                            ifid_instr  = w_buf_instr;
                            w_buf_clear = 1'b1;
                            if (opcode(w_buf_instr) == HALT_OP) begin
                                w_state_nxt = ST_HALTED;
                            end
                        end
                    end else begin
                        ic_req = 1'b1;
                        if (ic_done) begin
                            w_accept = 1'b1;
                        end else if (ic_stall) begin
                            w_state_nxt = ST_MISS;
                            if (!stall_in) begin
                                ifid_we     = 1'b1;
                                ifid_istall = 1'b1;
                            end
                        end
                    end
                end
                ST_MISS: begin
                    ic_req = 1'b1;
                    if (ic_done) begin
                        w_accept = 1'b1;
                    end else if (!stall_in) begin
                        ifid_we     = 1'b1;
                        ifid_istall = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    ic_req = 1'b1;
                    if (!stall_in) begin
                        ifid_we     = 1'b1;
                        ifid_istall = 1'b1;
                    end
                    if (ic_done) begin
                        w_pc_nxt    = r_tgt;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_HALTED: begin
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end

        // A HALT word never advances the PC, whether delivered now or parked in the buffer.
        if (w_accept) begin
            w_state_nxt = ST_RUN;
            if (stall_in) begin
                w_buf_load = 1'b1;
                if (opcode(ic_rdata) != HALT_OP) begin
                    w_pc_nxt = w_pc_plus2;
                end
            end else begin
                ifid_we    = 1'b1;
                ifid_pc    = w_pc_plus2;
                ifid_instr = ic_rdata;
                if (opcode(ic_rdata) == HALT_OP) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_pc_nxt = w_pc_plus2;
                end
            end
        end

        if (!rst) begin
            ic_req      = 1'b0;
            ifid_we     = 1'b0;
            ifid_pc     = '0;
            ifid_instr  = NOP_INSTR;
            ifid_flush  = 1'b0;
            ifid_istall = 1'b0;
            w_buf_load  = 1'b0;
            w_buf_clear = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_miss_cyc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
            r_miss_cyc  <= '0;
        end else begin
            if (ifid_we && !ifid_flush && !ifid_istall && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_in_miss && (r_miss_cyc != 16'hFFFF)) begin
                r_miss_cyc <= r_miss_cyc + 16'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_miss_cyc  = r_miss_cyc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IF/ID slots are queued as stimulus is driven
// and popped whenever the design raises ifid_we; control outputs are checked per cycle.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic [15:0] ic_rdata = '0;
    logic        ic_done = 1'b0;
    logic        ic_stall = 1'b0;
    logic        ifid_we;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_instr;
    logic        ifid_flush;
    logic        ifid_istall;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        flush;
        logic        istall;
        logic        chk_pc;
    } slot_t;

    slot_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_rdata       (ic_rdata),
        .ic_done        (ic_done),
        .ic_stall       (ic_stall),
        .ifid_we        (ifid_we),
        .ifid_pc        (ifid_pc),
        .ifid_instr     (ifid_instr),
        .ifid_flush     (ifid_flush),
        .ifid_istall    (ifid_istall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, want, $time);
        end
    endtask

    task automatic push_dlv(input logic [15:0] pc, input logic [15:0] instr);
        slot_t s;
        s.pc = pc; s.instr = instr; s.flush = 1'b0; s.istall = 1'b0; s.chk_pc = 1'b1;
        sb_q.push_back(s);
    endtask

    task automatic push_bub();
        slot_t s;
        s.pc = '0; s.instr = NOP; s.flush = 1'b0; s.istall = 1'b1; s.chk_pc = 1'b0;
        sb_q.push_back(s);
    endtask

    task automatic push_flush();
        slot_t s;
        s.pc = '0; s.instr = NOP; s.flush = 1'b1; s.istall = 1'b0; s.chk_pc = 1'b0;
        sb_q.push_back(s);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ic_req"},   ic_req,      1'b0);
        chk({tag, "_we"},       ifid_we,     1'b0);
        chk({tag, "_pc"},       ifid_pc,     16'h0000);
        chk({tag, "_instr"},    ifid_instr,  NOP);
        chk({tag, "_flush"},    ifid_flush,  1'b0);
        chk({tag, "_istall"},   ifid_istall, 1'b0);
    endtask

    // Called at posedge+1; drives one cycle, samples at the falling edge.
    // exp_req: -1 = do not check, 0/1 = required ic_req (ic_addr checked when 1).
    task automatic step(input logic done, input logic miss, input logic st,
                        input logic rv, input logic [15:0] rpc, input logic [15:0] rdata,
                        input int exp_req, input logic [15:0] exp_addr);
        slot_t s;
        ic_done        = done;
        ic_stall       = miss;
        stall_in       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_rdata       = rdata;
        @(negedge clk);
        if (exp_req >= 0) begin
            chk("ic_req", ic_req, exp_req[0]);
            if (exp_req == 1) chk("ic_addr", ic_addr, exp_addr);
        end
        if (ifid_we) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_we", ifid_we, 1'b0);
            end else begin
                s = sb_q.pop_front();
                chk("sb_instr",  ifid_instr,  s.instr);
                chk("sb_flush",  ifid_flush,  s.flush);
                chk("sb_istall", ifid_istall, s.istall);
                if (s.chk_pc) chk("sb_pc", ifid_pc, s.pc);
            end
        end
        chk("sb_missing_slot", sb_q.size(), 0);
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a stray cache completion: outputs must stay at reset values.
        rst = 1'b0; ic_done = 1'b1; ic_rdata = 16'h1234;
        #2;
        chk_reset("reset");
        ic_done = 1'b0;
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Hit streaming
        push_dlv(16'h0002, 16'h1111); step(1, 0, 0, 0, 16'h0, 16'h1111, 1, 16'h0000);
        push_dlv(16'h0004, 16'h2222); step(1, 0, 0, 0, 16'h0, 16'h2222, 1, 16'h0002);

        // Three-cycle miss at 0x0004
        for (int i = 0; i < 3; i++) begin
            push_bub(); step(0, 1, 0, 0, 16'h0, 16'h0, 1, 16'h0004);
        end
        push_dlv(16'h0006, 16'h3333); step(1, 0, 0, 0, 16'h0, 16'h3333, 1, 16'h0004);

        // Decode stall while a hit returns: buffered, then delivered once
        step(1, 0, 1, 0, 16'h0, 16'hABCD, 1, 16'h0006);
        step(0, 0, 1, 0, 16'h0, 16'h0000, 0, 16'h0000);
        push_dlv(16'h0008, 16'hABCD); step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0000);
        push_dlv(16'h000A, 16'h4444); step(1, 0, 0, 0, 16'h0, 16'h4444, 1, 16'h0008);

        // Redirect during miss, second redirect in DRAIN overwrites, drained data dropped
        push_bub();   step(0, 1, 0, 0, 16'h0,    16'h0000, 1, 16'h000A);
        push_flush(); step(0, 1, 0, 1, 16'h0030, 16'h0000, 1, 16'h000A);
        push_flush(); step(0, 1, 1, 1, 16'h0040, 16'h0000, 1, 16'h000A);
        step(1, 0, 1, 0, 16'h0, 16'hDEAD, 1, 16'h000A);
        push_dlv(16'h0042, 16'h5555); step(1, 0, 0, 0, 16'h0, 16'h5555, 1, 16'h0040);

        // Redirect together with completion: word dropped, target fetched next
        push_bub();   step(0, 1, 0, 0, 16'h0,    16'h0000, 1, 16'h0042);
        push_flush(); step(1, 0, 0, 1, 16'h0060, 16'hBAD1, 1, 16'h0042);
        push_dlv(16'h0062, 16'h9999); step(1, 0, 0, 0, 16'h0, 16'h9999, 1, 16'h0060);

        // HALT at 0x0010, idle, then redirect out
        push_flush(); step(0, 0, 0, 1, 16'h0010, 16'h0000, -1, 16'h0000);
        push_dlv(16'h0012, 16'h0123); step(1, 0, 0, 0, 16'h0, 16'h0123, 1, 16'h0010);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 16'h0, 16'h0000, 0, 16'h0000);
        end
        push_flush(); step(0, 0, 0, 1, 16'h0020, 16'h0000, -1, 16'h0000);
        push_dlv(16'h0022, 16'h6666); step(1, 0, 0, 0, 16'h0, 16'h6666, 1, 16'h0020);

        // PC wrap at 0xFFFE
        push_flush(); step(0, 0, 0, 1, 16'hFFFE, 16'h0000, -1, 16'h0000);
        push_dlv(16'h0000, 16'h7777); step(1, 0, 0, 0, 16'h0, 16'h7777, 1, 16'hFFFE);
        push_dlv(16'h0002, 16'h8888); step(1, 0, 0, 0, 16'h0, 16'h8888, 1, 16'h0000);

        // Reset in the middle of a miss
        push_bub(); step(0, 1, 0, 0, 16'h0, 16'h0000, 1, 16'h0002);
        ic_stall = 1'b1; ic_done = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
        rst = 1'b0;
        #2;
        chk_reset("midmiss_reset");
        chk("midmiss_reset_addr", ic_addr, 16'h0000);
        #2;
        rst = 1'b1;
        ic_stall = 1'b0;
        @(posedge clk);
        #1;
        push_dlv(16'h0002, 16'hAAAA); step(1, 0, 0, 0, 16'h0, 16'hAAAA, 1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
